// File: rtl/instruction_fetch.sv
// Fetch front end: owns the program counter, drives the synchronous instruction
// memory and buffers returned {pc, instr} pairs in a 2-entry skid FIFO for decode.
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  entry_t                fifo_q [2];
  entry_t                head;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign imem_addr = pc_q;
  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  assign pop  = out_valid & out_ready;
  assign push = inflight_q;

  // Words already buffered or returning next edge, minus the one leaving now;
  // issuing only below 2 is what keeps the FIFO from ever overflowing.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (occupancy < 3'd2);

  // NOTE: every next-state signal gets its hold value first so no path leaves
  // it unassigned; that is what prevents latch inference in always_comb.
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      pc_d     = redirect_addr;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_WIDTH'(1);
      end
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: the two FIFO slots are reset because out_pc/out_instr must read zero
  // during reset; a deeper storage array would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else if (push && !redirect_valid) begin
      fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: imem_data};
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// back-pressure and redirects, checked by a queue scoreboard of the program-order stream.
module tb_instruction_fetch;

  localparam int          DW       = 32;
  localparam int          AW       = 10;
  localparam logic [9:0]  RESET_PC = 10'h000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_pops = 0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t          exp_q [$];
  logic [AW-1:0] model_pc = RESET_PC;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + {22'b0, a};
  endfunction

  // Synchronous instruction memory: one cycle read latency.
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the expected stream is the program order from the last restart
  // point (reset or redirect target), consumed one entry per accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pc", 64'(out_pc), 64'(e.pc));
          check("out_instr", 64'(out_instr), 64'(e.instr));
          n_pops++;
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_addr;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        model_pc = model_pc + 10'd1;
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset_and_check_startup(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    step(1);
    check({tag, "_valid_after_edge1"}, 64'(out_valid), 64'd0);
    check({tag, "_addr_after_edge1"}, 64'(imem_addr), 64'(RESET_PC + 10'd1));
    step(1);
    check({tag, "_valid_after_edge2"}, 64'(out_valid), 64'd1);
    check({tag, "_pc_after_edge2"}, 64'(out_pc), 64'(RESET_PC));
    check({tag, "_instr_after_edge2"}, 64'(out_instr), 64'(mem_word(RESET_PC)));
    step(1);
    check({tag, "_pc_next"}, 64'(out_pc), 64'(RESET_PC + 10'd1));
  endtask

  task automatic redirect_to(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_addr  = target;
    step(1);
    redirect_valid = 1'b0;
    redirect_addr  = $urandom_range(0, 1023);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state with no clock edge required.
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_addr", 64'(imem_addr), 64'(RESET_PC));
    check("reset_pc", 64'(out_pc), 64'd0);
    check("reset_instr", 64'(out_instr), 64'd0);
    step(2);

    // T1: startup stream with decode always ready.
    out_ready = 1'b1;
    release_reset_and_check_startup("t1");
    step(5);

    // T2: stall fills the FIFO, issue stops, head holds.
    out_ready = 1'b0;
    step(5);
    check("t2_valid_stalled", 64'(out_valid), 64'd1);
    if (exp_q.size() > 0) begin
      check("t2_head_pc", 64'(out_pc), 64'(exp_q[0].pc));
      check("t2_addr_held", 64'(imem_addr), 64'(exp_q[0].pc + 10'd2));
    end else begin
      check("t2_model_ready", 64'd0, 64'd1);
    end
    out_ready = 1'b1;
    step(6);

    // T3: mid-stream redirect.
    redirect_to(10'h100);
    check("t3_valid_r", 64'(out_valid), 64'd0);
    check("t3_addr_r", 64'(imem_addr), 64'h100);
    step(1);
    check("t3_valid_r1", 64'(out_valid), 64'd0);
    step(1);
    check("t3_valid_r2", 64'(out_valid), 64'd1);
    check("t3_pc_r2", 64'(out_pc), 64'h100);
    step(4);

    // T4: redirect to the last word, pc wraps.
    redirect_to(10'h3FF);
    step(2);
    check("t4_pc_3ff", 64'(out_pc), 64'h3FF);
    step(1);
    check("t4_pc_000", 64'(out_pc), 64'h000);
    step(1);
    check("t4_pc_001", 64'(out_pc), 64'h001);
    step(3);

    // T5: redirect while stalled with a full FIFO.
    out_ready = 1'b0;
    step(4);
    redirect_to(10'h2A0);
    check("t5_valid_flushed", 64'(out_valid), 64'd0);
    check("t5_addr", 64'(imem_addr), 64'h2A0);
    step(2);
    check("t5_valid", 64'(out_valid), 64'd1);
    check("t5_first_pc", 64'(out_pc), 64'h2A0);
    out_ready = 1'b1;
    step(5);

    // T6: asynchronous reset between edges mid-stream.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6_valid_async", 64'(out_valid), 64'd0);
    check("t6_addr_async", 64'(imem_addr), 64'(RESET_PC));
    release_reset_and_check_startup("t6");
    step(3);

    // Randomized back-pressure and redirects.
    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_addr  = ($urandom_range(0, 1) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                                     : 10'($urandom_range(0, 1023));
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step(5);

    check("throughput_pops_over_1000", 64'(n_pops > 1000), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
